// File: rtl/bus_pkg.sv
// bus_pkg: shared types and constants for the 68000 bus cycle controller.
//   region_t  - bus cycle region classification (ROM, RAM, IO, EXP)
//   state_t   - cycle controller FSM states
//   *_NIB     - A[23:20] region nibbles
//   cnt_width - counter width able to hold 0..max_val
//   classify  - region decode from the address nibble, boot flag and RW
package bus_pkg;

  typedef enum logic [1:0] {
    ROM = 2'd0,
    RAM = 2'd1,
    IO  = 2'd2,
    EXP = 2'd3
  } region_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    ACK     = 3'd2,
    EXTWAIT = 3'd3,
    DONE    = 3'd4,
    BERR    = 3'd5
  } state_t;

  localparam logic [3:0] ROM_NIB = 4'hE;
  localparam logic [3:0] RAM_NIB = 4'h0;
  localparam logic [3:0] IO_NIB  = 4'hF;
  localparam logic [3:0] EXP_LO  = 4'h1;
  localparam logic [3:0] EXP_HI  = 4'hD;

  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

  // While the overlay is active (boot = 0), reads at 0x0 go to ROM.
  function automatic region_t classify(input logic [3:0] nib,
                                       input logic       boot,
                                       input logic       rw);
    region_t r;
    r = EXP;
    if (nib == ROM_NIB) begin
      r = ROM;
    end else if (nib == IO_NIB) begin
      r = IO;
    end else if (nib == RAM_NIB) begin
      r = (!boot && rw) ? ROM : RAM;
    end else if ((nib >= EXP_LO) && (nib <= EXP_HI)) begin
      r = EXP;
    end else begin
      r = EXP;
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_cycle_controller_if.sv
// bus_cycle_controller_if: CPU-side strobes and board DTACK/BERR/BOOT lines.
//   slave  modport - used by bus_cycle_controller (CPU strobes in, acks out)
//   master modport - used by whatever drives the CPU strobes
interface bus_cycle_controller_if;
  logic [23:18] i_A;
  logic         i_AS_n;
  logic         i_RW;
  logic         i_CPUSP_n;
  logic         i_LGEXP_n;
  logic         i_DTACK_n;
  logic         o_PPDTACK;
  logic         o_BERR_n;
  logic         o_BOOT;

  modport slave (
    input  i_A, i_AS_n, i_RW, i_CPUSP_n, i_LGEXP_n, i_DTACK_n,
    output o_PPDTACK, o_BERR_n, o_BOOT
  );

  modport master (
    output i_A, i_AS_n, i_RW, i_CPUSP_n, i_LGEXP_n, i_DTACK_n,
    input  o_PPDTACK, o_BERR_n, o_BOOT
  );
endinterface

// File: rtl/cycle_timer.sv
// cycle_timer: loadable counter with a zero flag, synchronous active-low reset.
//   COUNT_UP = 0: down-counter saturating at zero (wait states)
//   COUNT_UP = 1: up-counter saturating at all-ones (watchdog)
//   clk, rst_n     - clock and synchronous active-low reset
//   load, load_val - load takes priority over en
//   en             - count one step
//   count, zero    - current value and (count == 0)
module cycle_timer #(
  parameter int WIDTH    = 4,
  parameter bit COUNT_UP = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_next_s;

  // Next count: load, saturating step, or hold.
  always_comb begin
    count_next_s = count_r;
    if (load) begin
      count_next_s = load_val;
    end else if (en) begin
      if (COUNT_UP) begin
        if (count_r != {WIDTH{1'b1}}) begin
          count_next_s = count_r + WIDTH'(1);
        end else begin
          count_next_s = count_r;
        end
      end else begin
        if (count_r != {WIDTH{1'b0}}) begin
          count_next_s = count_r - WIDTH'(1);
        end else begin
          count_next_s = count_r;
        end
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= {WIDTH{1'b0}};
    end else begin
      count_r <= count_next_s;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/bus_cycle_controller.sv
// bus_cycle_controller: classifies 68000 bus cycles by region, generates
// DTACK after a per-region wait count, owns the boot-overlay flag and
// optionally raises BERR when nothing acknowledges a cycle.
//   i_CLK      - CPU clock, all state changes on the rising edge
//   i_RESET_n  - synchronous active-low reset
//   bus        - slave modport: i_A, i_AS_n, i_RW, i_CPUSP_n, i_LGEXP_n,
//                i_DTACK_n in; o_PPDTACK, o_BERR_n, o_BOOT out
// Optional feature macro: BUS_BERR_WATCHDOG_EN compiles in the watchdog and
// BERR state; without it o_BERR_n is tied high and BERR_TIMEOUT is ignored.
module bus_cycle_controller
  import bus_pkg::*;
#(
  parameter int ROM_WAIT      = 2,
  parameter int RAM_WAIT      = 0,
  parameter int EXP_WAIT      = 1,
  parameter int BOOT_AS_COUNT = 4,
  parameter int BERR_TIMEOUT  = 64
) (
  input logic                   i_CLK,
  input logic                   i_RESET_n,
  bus_cycle_controller_if.slave bus
);

  localparam int WAIT_MAX = (ROM_WAIT > RAM_WAIT) ?
                            ((ROM_WAIT > EXP_WAIT) ? ROM_WAIT : EXP_WAIT) :
                            ((RAM_WAIT > EXP_WAIT) ? RAM_WAIT : EXP_WAIT);
  localparam int WAIT_W = cnt_width(WAIT_MAX);
  localparam int BOOT_W = cnt_width(BOOT_AS_COUNT);

  state_t            state_r;
  state_t            next_state_s;
  region_t           cls_s;
  logic              ext_s;
  logic [WAIT_W-1:0] wait_load_val_s;
  logic              wait_load_s;
  logic              wait_en_s;
  logic [WAIT_W-1:0] wait_count_s;
  logic              wait_zero_s;
  logic              boot_inc_s;
  logic [BOOT_W-1:0] boot_cnt_r;
  logic [BOOT_W-1:0] boot_cnt_next_s;
  logic              boot_next_s;
  logic              boot_r;
  logic              ppdtack_r;
  logic              unused_s;

  // Region decode and its wait count, consumed only on the IDLE start edge.
  always_comb begin
    cls_s           = classify(bus.i_A[23:20], boot_r, bus.i_RW);
    ext_s           = (cls_s == IO) || ((cls_s == EXP) && bus.i_LGEXP_n) || !bus.i_CPUSP_n;
    wait_load_val_s = {WAIT_W{1'b0}};
    case (cls_s)
      ROM:     wait_load_val_s = WAIT_W'(ROM_WAIT);
      RAM:     wait_load_val_s = WAIT_W'(RAM_WAIT);
      EXP:     wait_load_val_s = WAIT_W'(EXP_WAIT);
      default: wait_load_val_s = {WAIT_W{1'b0}};
    endcase
  end

  cycle_timer #(.WIDTH(WAIT_W), .COUNT_UP(1'b0)) u_wait_timer (
    .clk      (i_CLK),
    .rst_n    (i_RESET_n),
    .load     (wait_load_s),
    .en       (wait_en_s),
    .load_val (wait_load_val_s),
    .count    (wait_count_s),
    .zero     (wait_zero_s)
  );

`ifdef BUS_BERR_WATCHDOG_EN
  localparam int WD_W = cnt_width(BERR_TIMEOUT);

  logic            wd_load_s;
  logic            wd_en_s;
  logic [WD_W-1:0] wd_count_s;
  logic            wd_zero_s;
  logic            wd_hit_s;
  logic            berr_n_r;

  cycle_timer #(.WIDTH(WD_W), .COUNT_UP(1'b1)) u_watchdog (
    .clk      (i_CLK),
    .rst_n    (i_RESET_n),
    .load     (wd_load_s),
    .en       (wd_en_s),
    .load_val ({WD_W{1'b0}}),
    .count    (wd_count_s),
    .zero     (wd_zero_s)
  );

  // The watchdog reaches BERR_TIMEOUT on the edge where it holds TIMEOUT-1.
  assign wd_hit_s = (wd_count_s == WD_W'(BERR_TIMEOUT - 1));
  assign unused_s = ^{bus.i_A[19:18], wait_count_s, wd_zero_s};
`else
  assign unused_s = ^{bus.i_A[19:18], wait_count_s, (BERR_TIMEOUT != 0)};
`endif

  // FSM next state and counter controls.
  always_comb begin
    next_state_s = state_r;
    wait_load_s  = 1'b0;
    wait_en_s    = 1'b0;
    boot_inc_s   = 1'b0;
`ifdef BUS_BERR_WATCHDOG_EN
    wd_load_s    = 1'b0;
    wd_en_s      = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        wait_load_s = 1'b1;
`ifdef BUS_BERR_WATCHDOG_EN
        wd_load_s   = 1'b1;
`endif
        if (!bus.i_AS_n) begin
          next_state_s = ext_s ? EXTWAIT : WAIT;
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT: begin
`ifdef BUS_BERR_WATCHDOG_EN
        wd_en_s = !bus.i_AS_n;
`endif
        if (bus.i_AS_n) begin
          next_state_s = IDLE;
        end else if (wait_zero_s) begin
          next_state_s = ACK;
        end else begin
          wait_en_s    = 1'b1;
          next_state_s = WAIT;
        end
      end
      ACK: begin
        if (bus.i_AS_n) begin
          next_state_s = IDLE;
          boot_inc_s   = 1'b1;
        end else begin
          next_state_s = ACK;
        end
      end
      EXTWAIT: begin
`ifdef BUS_BERR_WATCHDOG_EN
        wd_en_s = !bus.i_AS_n;
`endif
        // A DTACK arriving on the timeout edge takes priority over BERR.
        if (bus.i_AS_n) begin
          next_state_s = IDLE;
        end else if (!bus.i_DTACK_n) begin
          next_state_s = DONE;
`ifdef BUS_BERR_WATCHDOG_EN
        end else if (wd_hit_s) begin
          next_state_s = BERR;
`endif
        end else begin
          next_state_s = EXTWAIT;
        end
      end
      DONE: begin
        if (bus.i_AS_n) begin
          next_state_s = IDLE;
          boot_inc_s   = 1'b1;
        end else begin
          next_state_s = DONE;
        end
      end
      BERR: begin
        if (bus.i_AS_n) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = BERR;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Saturating boot counter; the overlay drops on the Nth completed cycle.
  always_comb begin
    boot_cnt_next_s = boot_cnt_r;
    boot_next_s     = boot_r;
    if (boot_inc_s && (boot_cnt_r != BOOT_W'(BOOT_AS_COUNT))) begin
      boot_cnt_next_s = boot_cnt_r + BOOT_W'(1);
      if (boot_cnt_r == BOOT_W'(BOOT_AS_COUNT - 1)) begin
        boot_next_s = 1'b1;
      end else begin
        boot_next_s = boot_r;
      end
    end else begin
      boot_cnt_next_s = boot_cnt_r;
    end
  end

  // State, boot flag and DTACK register. DTACK is held for one edge after
  // leaving ACK so it negates one edge after AS is seen high.
  always_ff @(posedge i_CLK) begin
    if (!i_RESET_n) begin
      state_r    <= IDLE;
      boot_cnt_r <= {BOOT_W{1'b0}};
      boot_r     <= 1'b0;
      ppdtack_r  <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      boot_cnt_r <= boot_cnt_next_s;
      boot_r     <= boot_next_s;
      ppdtack_r  <= (next_state_s == ACK) || (state_r == ACK);
    end
  end

`ifdef BUS_BERR_WATCHDOG_EN
  // BERR output, negated one edge after AS is seen high.
  always_ff @(posedge i_CLK) begin
    if (!i_RESET_n) begin
      berr_n_r <= 1'b1;
    end else begin
      berr_n_r <= !((next_state_s == BERR) || (state_r == BERR));
    end
  end

  assign bus.o_BERR_n = berr_n_r;
`else
  assign bus.o_BERR_n = 1'b1;
`endif

  assign bus.o_PPDTACK = ppdtack_r;
  assign bus.o_BOOT    = boot_r;

endmodule

// File: doc/bus_cycle_controller.md
# bus_cycle_controller

Sequential companion to the 68000 address decoder. It classifies each CPU bus cycle by region and generates DTACK after a per-region wait-state count. It owns the boot-overlay flag that the decoder consumes as BOOT, and can raise BERR when no device acknowledges a cycle. It sits between the CPU strobes and the board DTACK/BERR lines, clocked by the CPU clock.

## Interface
Parameters:
- ROM_WAIT, 2: wait states for ROM cycles (0xE00000 and overlay reads).
- RAM_WAIT, 0: wait states for RAM cycles (0x000000–0x0FFFFF).
- EXP_WAIT, 1: wait states for on-board expansion acknowledge.
- BOOT_AS_COUNT, 4: completed bus cycles before the overlay is released.
- BERR_TIMEOUT, 64: cycles with AS low and no DTACK before BERR.

Ports:
- i_CLK  in  1  CPU clock; all state updates on the rising edge.
- i_RESET_n  in  1  reset, synchronous, active-low.
- i_A  in  [23:18]  CPU address high bits.
- i_AS_n  in  1  address strobe.
- i_RW  in  1  1 = read.
- i_CPUSP_n  in  1  low = CPU-space cycle (IACK etc.).
- i_LGEXP_n  in  1  low = expansion region is acknowledged locally.
- i_DTACK_n  in  1  sampled board DTACK line (any source).
- o_PPDTACK  out  1  1 = drive DTACK low; the top level performs the tri-state.
- o_BERR_n  out  1  bus error, active-low.
- o_BOOT  out  1  0 = ROM overlay at 0x000000 for reads; 1 = normal map.

## Operation
- Region from i_A[23:20], latched at cycle start:
  - ROM if 0xE, or if 0x0 with o_BOOT=0 and i_RW=1.
  - RAM if 0x0 otherwise.
  - IO if 0xF.
  - EXP if 0x1–0xD.
- No internal acknowledge for IO, for EXP with i_LGEXP_n=1, or for i_CPUSP_n=0. These are external-ACK cycles.
- States:
  - IDLE: i_AS_n sampled low → latch region, load the wait counter (region's *_WAIT), go to WAIT. External-ACK regions go to EXTWAIT.
  - WAIT: counter decrements each cycle; at 0 → ACK.
  - ACK: o_PPDTACK=1; hold until i_AS_n sampled high → IDLE.
  - EXTWAIT: wait for i_DTACK_n low → DONE, or watchdog expiry → BERR.
  - DONE: wait for i_AS_n high → IDLE.
  - BERR: o_BERR_n=0 until i_AS_n sampled high → IDLE.
- i_AS_n sampled high while in WAIT (aborted cycle) → IDLE immediately, no acknowledge.
- Boot counter:
  - Increments on each transition into IDLE from ACK or DONE; BERR terminations are not counted.
  - When the count reaches BOOT_AS_COUNT, o_BOOT←1 and stays 1 until reset. The counter saturates.
- Watchdog:
  - Counts cycles while AS is low in WAIT, ACK-pending or EXTWAIT.
  - Cleared in IDLE.
  - Width is clog2(BERR_TIMEOUT+1).

## Timing
- Reset values: o_PPDTACK=0, o_BERR_n=1, o_BOOT=0, state IDLE, all counters 0.
- Reset asserted mid-cycle: outputs take their reset values on that edge. No DTACK or BERR is produced for the interrupted cycle.
- Latency: AS low sampled at edge k → o_PPDTACK=1 at edge k+1+WAIT. WAIT=0 gives one cycle.
- Deassert: i_AS_n high sampled at edge m → o_PPDTACK=0 and o_BERR_n=1 at edge m+1.
- Back-to-back: i_AS_n low at the IDLE-entry edge starts a new cycle on the next edge. There is no dead cycle beyond that.
- Simultaneous events: i_DTACK_n low on the same edge the watchdog reaches BERR_TIMEOUT → DTACK wins, no BERR.
- Boot release: o_BOOT changes on the same edge as the Nth return to IDLE. The next cycle decodes with the new map.

## Configuration
- BUS_BERR_WATCHDOG_EN defined: watchdog counter and the BERR state are compiled in, as described above.
- Not defined:
  - Watchdog and BERR state are removed; o_BERR_n is tied to 1.
  - EXTWAIT exits only on i_DTACK_n low, or on i_AS_n high (goes to IDLE, not counted for boot).
  - BERR_TIMEOUT is ignored.

## Structure
- Shared package bus_pkg holds:
  - region_t enum (ROM, RAM, IO, EXP).
  - state_t enum (IDLE, WAIT, ACK, EXTWAIT, DONE, BERR).
  - Region nibble constants: ROM_NIB=4'hE, RAM_NIB=4'h0, IO_NIB=4'hF, EXP_LO=4'h1, EXP_HI=4'hD.
- One sub-module, cycle_timer: a loadable down-counter with a zero flag, used for wait states. The watchdog reuses the same module in up-count form, selected by parameter.

## Test plan
- RAM read at 0x000000, o_BOOT=1, RAM_WAIT=0: AS low at edge 0 → PPDTACK=1 at edge 1; AS high at edge 3 → PPDTACK=0 at edge 4.
- After reset, read 0x000000: ROM wait (PPDTACK at edge 3). Four complete cycles → o_BOOT=1 on the 4th IDLE entry. The next read at 0x000000 uses the RAM wait.
- Write 0x000000 with o_BOOT=0: classed RAM, PPDTACK after 1 cycle.
- IO read 0xF00000 with no external DTACK (BUS_BERR_WATCHDOG_EN defined): o_BERR_n=0 after 64 cycles, released one edge after AS high. The boot counter does not advance.
- EXP 0x100000 with i_LGEXP_n=1: external DTACK at cycle 10 → no BERR, PPDTACK stays 0. The same cycle with DTACK arriving exactly at timeout → no BERR.
- Reset asserted during ROM WAIT: PPDTACK stays 0, state IDLE, o_BOOT=0, boot count cleared.
